sdram_port_arbiter: RTL and testbench

Shares the single-word host interface of sdram_controller between two requesters: the camera write path (OV7670 pixel writer) and the display read path (ILI9341 fetcher). It grants one requester at a time, drives the controller's wr_enable/rd_enable against its busy flag, and returns a one-cycle acknowledge to the granted port. Read data is returned to the display port with a valid strobe. It sits between the capture/display logic and sdram_controller.

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_port_arbiter_rr_arb2.sv | 31 +++
 rtl/sdram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM host arbiter.
// Holds the FSM state encoding, grant identifiers and default widths.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 16;

    localparam logic GRANT_CAM = 1'b0;
    localparam logic GRANT_LCD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_rr_arb2.sv
// Two-input picker: round-robin on ties, or display-first when RD_PRIORITY=1.
// Ports: i_req_cam/i_req_lcd requests, i_last_grant, o_grant index, o_valid.
module rr_arb2
    import sdram_arb_pkg::*;
#(
    parameter int RD_PRIORITY = 0
) (
    input  logic i_req_cam,
    input  logic i_req_lcd,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_valid
);

    always_comb begin
        o_valid = i_req_cam | i_req_lcd;
        o_grant = GRANT_CAM;
        unique case (1'b1)
            (i_req_cam && i_req_lcd): begin
                // Tie: the port that did not win last time goes next.
                if (RD_PRIORITY != 0)
                    o_grant = GRANT_LCD;
                else
                    o_grant = ~i_last_grant;
            end
            (i_req_lcd && !i_req_cam): o_grant = GRANT_LCD;
            default:                   o_grant = GRANT_CAM;
        endcase
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the sdram_controller single-word host port between the camera
// writer and display reader, one transaction at a time.
// Ports: cam_* write requester, lcd_* read requester, sd_* controller side,
// grant_id current/last owner, timeout_err sticky ISSUE-timeout flag.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RD_PRIORITY = 0,
    parameter int ACK_TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_ack,
    input  logic              lcd_req,
    input  logic [ADDR_W-1:0] lcd_addr,
    output logic              lcd_ack,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_valid,
    output logic [ADDR_W-1:0] sd_wr_addr,
    output logic [DATA_W-1:0] sd_wr_data,
    input  logic [DATA_W-1:0] sd_rd_data,
    input  logic              sd_busy,
    output logic              sd_wr_enable,
    output logic              sd_rd_enable,
    output logic              grant_id,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    arb_state_t       r_state;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic             w_grant;
    logic             w_grant_vld;

    rr_arb2 #(
        .RD_PRIORITY (RD_PRIORITY)
    ) u_pick (
        .i_req_cam    (cam_req),
        .i_req_lcd    (lcd_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_grant_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_LCD;
            r_cnt        <= '0;
            cam_ack      <= 1'b0;
            lcd_ack      <= 1'b0;
            lcd_valid    <= 1'b0;
            lcd_data     <= '0;
            sd_wr_addr   <= '0;
            sd_wr_data   <= '0;
            sd_wr_enable <= 1'b0;
            sd_rd_enable <= 1'b0;
            grant_id     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            cam_ack   <= 1'b0;
            lcd_ack   <= 1'b0;
            lcd_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // Controller busy (init/refresh) holds off all grants.
                    if (!sd_busy && w_grant_vld) begin
                        grant_id <= w_grant;
                        r_cnt    <= '0;
                        r_state  <= ST_ISSUE;
                        if (w_grant == GRANT_LCD) begin
                            sd_wr_addr   <= lcd_addr;
                            sd_rd_enable <= 1'b1;
                        end else begin
                            sd_wr_addr   <= cam_addr;
                            sd_wr_data   <= cam_data;
                            sd_wr_enable <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (sd_busy) begin
                        sd_wr_enable <= 1'b0;
                        sd_rd_enable <= 1'b0;
                        r_state      <= ST_BUSY;
                    end else if (r_cnt == CNT_LAST) begin
                        // Give up; the held request is re-arbitrated.
                        sd_wr_enable <= 1'b0;
                        sd_rd_enable <= 1'b0;
                        timeout_err  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BUSY: begin
                    // Ack is registered here so it is high during DONE.
                    if (!sd_busy) begin
                        r_state <= ST_DONE;
                        if (grant_id == GRANT_LCD) begin
                            lcd_ack   <= 1'b1;
                            lcd_valid <= 1'b1;
                            lcd_data  <= sd_rd_data;
                        end else begin
                            cam_ack <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_last_grant <= grant_id;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural controller.
// Instance 0 is round-robin, instance 1 is display-priority.
module tb_sdram_port_arbiter;

    localparam int AW       = 25;
    localparam int DW       = 16;
    localparam int BUSY_LEN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cam_req;
    logic          lcd_req;
    logic [AW-1:0] cam_addr;
    logic [AW-1:0] lcd_addr;
    logic [DW-1:0] cam_data;

    logic          cam_ack      [2];
    logic          lcd_ack      [2];
    logic [DW-1:0] lcd_data     [2];
    logic          lcd_valid    [2];
    logic [AW-1:0] sd_wr_addr   [2];
    logic [DW-1:0] sd_wr_data   [2];
    logic [DW-1:0] sd_rd_data   [2];
    logic          sd_busy      [2];
    logic          sd_wr_enable [2];
    logic          sd_rd_enable [2];
    logic          grant_id     [2];
    logic          timeout_err  [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sdram_port_arbiter #(
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .RD_PRIORITY (k),
            .ACK_TIMEOUT (32)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .cam_req      (cam_req),
            .cam_addr     (cam_addr),
            .cam_data     (cam_data),
            .cam_ack      (cam_ack[k]),
            .lcd_req      (lcd_req),
            .lcd_addr     (lcd_addr),
            .lcd_ack      (lcd_ack[k]),
            .lcd_data     (lcd_data[k]),
            .lcd_valid    (lcd_valid[k]),
            .sd_wr_addr   (sd_wr_addr[k]),
            .sd_wr_data   (sd_wr_data[k]),
            .sd_rd_data   (sd_rd_data[k]),
            .sd_busy      (sd_busy[k]),
            .sd_wr_enable (sd_wr_enable[k]),
            .sd_rd_enable (sd_rd_enable[k]),
            .grant_id     (grant_id[k]),
            .timeout_err  (timeout_err[k])
        );
    end

    logic          ctl_never;
    logic          ctl_force;
    logic [DW-1:0] ctl_rd_word;

    int   bcnt     [2];
    logic rd_op    [2];
    logic en_q     [2];
    int   cam_acks [2];
    int   lcd_acks [2];
    int   valids   [2];
    int   en_cyc   [2];
    bit   glog0 [$];
    bit   glog1 [$];

    int checks = 0;
    int errors = 0;

    // Behavioural controller plus ack/grant monitors per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                sd_busy[k]    <= 1'b0;
                sd_rd_data[k] <= '0;
                bcnt[k]       <= 0;
                rd_op[k]      <= 1'b0;
                en_q[k]       <= 1'b0;
                cam_acks[k]   <= 0;
                lcd_acks[k]   <= 0;
                valids[k]     <= 0;
                en_cyc[k]     <= 0;
            end else begin
                en_q[k] <= sd_wr_enable[k] | sd_rd_enable[k];
                if (cam_ack[k] === 1'b1) cam_acks[k] <= cam_acks[k] + 1;
                if (lcd_ack[k] === 1'b1) lcd_acks[k] <= lcd_acks[k] + 1;
                if (lcd_valid[k] === 1'b1) valids[k] <= valids[k] + 1;
                if (sd_wr_enable[k] | sd_rd_enable[k])
                    en_cyc[k] <= en_cyc[k] + 1;
                if (ctl_force) begin
                    sd_busy[k] <= 1'b1;
                end else if (bcnt[k] != 0) begin
                    bcnt[k] <= bcnt[k] - 1;
                    if (bcnt[k] == 1) begin
                        sd_busy[k] <= 1'b0;
                        if (rd_op[k]) sd_rd_data[k] <= ctl_rd_word;
                    end
                end else if ((sd_wr_enable[k] | sd_rd_enable[k])
                             && !ctl_never) begin
                    sd_busy[k] <= 1'b1;
                    bcnt[k]    <= BUSY_LEN;
                    rd_op[k]   <= sd_rd_enable[k];
                end else begin
                    sd_busy[k] <= 1'b0;
                end
            end
        end
        if (!rst_n) begin
            glog0.delete();
            glog1.delete();
        end else begin
            if ((sd_wr_enable[0] | sd_rd_enable[0]) && !en_q[0])
                glog0.push_back(sd_rd_enable[0]);
            if ((sd_wr_enable[1] | sd_rd_enable[1]) && !en_q[1])
                glog1.push_back(sd_rd_enable[1]);
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        cam_req   = 1'b0;
        lcd_req   = 1'b0;
        ctl_never = 1'b0;
        ctl_force = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns cycles until the ack is seen, or -1 when the bound expires.
    task automatic wait_ack(input int k, input bit lcd, input int bound,
                            output int n);
        n = 0;
        while (n >= 0) begin
            @(negedge clk);
            n++;
            if ((lcd ? lcd_ack[k] : cam_ack[k]) === 1'b1) break;
            if (n >= bound) n = -1;
        end
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        rst_n = 1'b0; cam_req = 1'b0; lcd_req = 1'b0;
        ctl_never = 1'b0; ctl_force = 1'b0;
        cam_addr = 25'h1; cam_data = 16'h1; lcd_addr = 25'h2;
        @(negedge clk);
        @(negedge clk);
        flags = {cam_ack[0], lcd_ack[0], lcd_valid[0], sd_wr_enable[0],
                 sd_rd_enable[0], grant_id[0], timeout_err[0]};
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000", flags);
        end
        checks++;
        if (sd_wr_addr[0] !== '0 || sd_wr_data[0] !== '0
            || lcd_data[0] !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h lcd %h want 0",
                     sd_wr_addr[0], sd_wr_data[0], lcd_data[0]);
        end
        cam_req = 1'b1; lcd_req = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({grant_id[0], sd_wr_enable[0]} !== 2'b01) begin
            errors++;
            $display("FAIL first_tie_rr: got %b want 01",
                     {grant_id[0], sd_wr_enable[0]});
        end
        checks++;
        if ({grant_id[1], sd_rd_enable[1]} !== 2'b11) begin
            errors++;
            $display("FAIL first_tie_prio: got %b want 11",
                     {grant_id[1], sd_rd_enable[1]});
        end
        cam_req = 1'b0; lcd_req = 1'b0;
    endtask

    task automatic test_cam_write();
        int n;
        do_reset();
        cam_addr = 25'hfedbed; cam_data = 16'd3333;
        cam_req = 1'b1;
        wait_ack(0, 1'b0, 30, n);
        cam_req = 1'b0;
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL cam_latency: got %0d want 7", n);
        end
        checks++;
        if (sd_wr_addr[0] !== 25'hfedbed || sd_wr_data[0] !== 16'd3333) begin
            errors++;
            $display("FAIL cam_addr_data: got %h/%0d want fedbed/3333",
                     sd_wr_addr[0], sd_wr_data[0]);
        end
        checks++;
        if (grant_id[0] !== 1'b0 || lcd_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL cam_grant: grant %b valid %b want 0 0",
                     grant_id[0], lcd_valid[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cam_acks[0] !== 1 || lcd_acks[0] !== 0) begin
            errors++;
            $display("FAIL cam_ack_count: cam %0d lcd %0d want 1 0",
                     cam_acks[0], lcd_acks[0]);
        end
        checks++;
        if (en_cyc[0] !== 2 || sd_wr_enable[0] !== 1'b0) begin
            errors++;
            $display("FAIL cam_enable_len: got %0d cycles en %b want 2 0",
                     en_cyc[0], sd_wr_enable[0]);
        end
    endtask

    task automatic test_lcd_read();
        int n;
        do_reset();
        ctl_rd_word = 16'hbbbb;
        lcd_addr = 25'hbedfed;
        lcd_req = 1'b1;
        wait_ack(0, 1'b1, 30, n);
        lcd_req = 1'b0;
        checks++;
        if (n !== 7 || lcd_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL lcd_ack_valid: got n=%0d valid %b want 7 1",
                     n, lcd_valid[0]);
        end
        checks++;
        if (lcd_data[0] !== 16'hbbbb || sd_wr_addr[0] !== 25'hbedfed
            || grant_id[0] !== 1'b1) begin
            errors++;
            $display("FAIL lcd_data: got %h addr %h grant %b want bbbb bedfed 1",
                     lcd_data[0], sd_wr_addr[0], grant_id[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (lcd_acks[0] !== 1 || valids[0] !== 1 || cam_acks[0] !== 0
            || lcd_valid[0] !== 1'b0 || lcd_data[0] !== 16'hbbbb) begin
            errors++;
            $display("FAIL lcd_pulse: acks %0d valids %0d cam %0d v %b d %h",
                     lcd_acks[0], valids[0], cam_acks[0],
                     lcd_valid[0], lcd_data[0]);
        end
    endtask

    task automatic test_round_robin();
        int nack;
        int cyc;
        logic [7:0] seq;
        do_reset();
        ctl_rd_word = 16'h1234;
        cam_addr = 25'h100; cam_data = 16'h0a0a; lcd_addr = 25'h200;
        cam_req = 1'b1; lcd_req = 1'b1;
        nack = 0; cyc = 0;
        while (nack < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cam_ack[0] === 1'b1 || lcd_ack[0] === 1'b1) nack++;
        end
        cam_req = 1'b0; lcd_req = 1'b0;
        repeat (4) @(negedge clk);
        seq = '0;
        foreach (glog0[i]) if (i < 8) seq[i] = glog0[i];
        checks++;
        if (nack !== 4 || glog0.size() !== 4 || seq !== 8'b0000_1010) begin
            errors++;
            $display("FAIL rr_order: acks %0d grants %0d seq %b want 4 4 00001010",
                     nack, glog0.size(), seq);
        end
        checks++;
        if (cam_acks[0] !== 2 || lcd_acks[0] !== 2) begin
            errors++;
            $display("FAIL rr_counts: cam %0d lcd %0d want 2 2",
                     cam_acks[0], lcd_acks[0]);
        end
    endtask

    task automatic test_priority();
        int nl;
        int nc;
        int cyc;
        logic [7:0] seq;
        do_reset();
        ctl_rd_word = 16'h4321;
        cam_addr = 25'h300; cam_data = 16'h0b0b; lcd_addr = 25'h400;
        cam_req = 1'b1; lcd_req = 1'b1;
        nl = 0; nc = 0; cyc = 0;
        while (nc < 1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (lcd_ack[1] === 1'b1) begin
                nl++;
                if (nl == 3) lcd_req = 1'b0;
            end
            if (cam_ack[1] === 1'b1) begin
                nc++;
                cam_req = 1'b0;
            end
        end
        cam_req = 1'b0; lcd_req = 1'b0;
        repeat (4) @(negedge clk);
        seq = '0;
        foreach (glog1[i]) if (i < 8) seq[i] = glog1[i];
        checks++;
        if (glog1.size() !== 4 || seq !== 8'b0000_0111) begin
            errors++;
            $display("FAIL prio_order: grants %0d seq %b want 4 00000111",
                     glog1.size(), seq);
        end
        checks++;
        if (lcd_acks[1] !== 3 || cam_acks[1] !== 1) begin
            errors++;
            $display("FAIL prio_counts: lcd %0d cam %0d want 3 1",
                     lcd_acks[1], cam_acks[1]);
        end
    endtask

    task automatic test_timeout();
        int n;
        int cyc;
        do_reset();
        ctl_never = 1'b1;
        cam_addr = 25'h0abcde; cam_data = 16'h7777;
        cam_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (sd_wr_enable[0] !== 1'b1 && cyc < 10);
        n = 0;
        while (sd_wr_enable[0] === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL timeout_len: got %0d want 32", n);
        end
        checks++;
        if (timeout_err[0] !== 1'b1 || cam_acks[0] !== 0) begin
            errors++;
            $display("FAIL timeout_flag: err %b acks %0d want 1 0",
                     timeout_err[0], cam_acks[0]);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (sd_wr_enable[0] !== 1'b1 && cyc < 10);
        @(negedge clk);
        checks++;
        if (glog0.size() !== 2 || sd_wr_addr[0] !== 25'h0abcde) begin
            errors++;
            $display("FAIL timeout_reissue: grants %0d addr %h want 2 0abcde",
                     glog0.size(), sd_wr_addr[0]);
        end
        ctl_never = 1'b0;
        wait_ack(0, 1'b0, 40, n);
        cam_req = 1'b0;
        checks++;
        if (n < 0 || timeout_err[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover: n %0d err %b want ack and 1",
                     n, timeout_err[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cam_acks[0] !== 1 || timeout_err[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: acks %0d err %b want 1 1",
                     cam_acks[0], timeout_err[0]);
        end
    endtask

    task automatic test_reset_busy();
        int n;
        int cyc;
        logic [6:0] flags;
        do_reset();
        ctl_rd_word = 16'hc0de;
        lcd_addr = 25'h123;
        lcd_req = 1'b1;
        wait_ack(0, 1'b1, 30, n);
        checks++;
        if (lcd_data[0] !== 16'hc0de) begin
            errors++;
            $display("FAIL rstb_first: got %h want c0de", lcd_data[0]);
        end
        ctl_rd_word = 16'h5a5a;
        lcd_addr = 25'h456;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(sd_busy[0] === 1'b1 && sd_rd_enable[0] === 1'b0)
                   && cyc < 20);
        rst_n = 1'b0;
        @(negedge clk);
        flags = {cam_ack[0], lcd_ack[0], lcd_valid[0], sd_wr_enable[0],
                 sd_rd_enable[0], grant_id[0], timeout_err[0]};
        checks++;
        if (flags !== 7'b0 || lcd_data[0] !== '0 || sd_wr_addr[0] !== '0) begin
            errors++;
            $display("FAIL rstb_clear: flags %b lcd %h addr %h want 0",
                     flags, lcd_data[0], sd_wr_addr[0]);
        end
        rst_n = 1'b1;
        wait_ack(0, 1'b1, 30, n);
        lcd_req = 1'b0;
        checks++;
        if (n !== 7 || lcd_data[0] !== 16'h5a5a || sd_wr_addr[0] !== 25'h456) begin
            errors++;
            $display("FAIL rstb_regrant: n %0d data %h addr %h want 7 5a5a 456",
                     n, lcd_data[0], sd_wr_addr[0]);
        end
    endtask

    task automatic test_busy_block();
        int n;
        do_reset();
        ctl_force = 1'b1;
        repeat (2) @(negedge clk);
        cam_addr = 25'h777; cam_data = 16'h0c0c;
        cam_req = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (sd_wr_enable[0] !== 1'b0 || glog0.size() !== 0) begin
            errors++;
            $display("FAIL busy_block: en %b grants %0d want 0 0",
                     sd_wr_enable[0], glog0.size());
        end
        ctl_force = 1'b0;
        wait_ack(0, 1'b0, 30, n);
        cam_req = 1'b0;
        checks++;
        if (n !== 8 || sd_wr_data[0] !== 16'h0c0c) begin
            errors++;
            $display("FAIL busy_release: n %0d data %h want 8 0c0c",
                     n, sd_wr_data[0]);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        cam_req     = 1'b0;
        lcd_req     = 1'b0;
        cam_addr    = '0;
        cam_data    = '0;
        lcd_addr    = '0;
        ctl_never   = 1'b0;
        ctl_force   = 1'b0;
        ctl_rd_word = '0;
        test_reset();
        test_cam_write();
        test_lcd_read();
        test_round_robin();
        test_priority();
        test_timeout();
        test_reset_busy();
        test_busy_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
